// File: rtl/horner_poly_eval.sv
// Fixed-point Horner evaluator y = C[N-1] - z*(C[N-2] - z*(... - z*C[0])), optionally scaled by ccs.
// Private pipelined multiplier, saturating subtract, run-time writable coefficient table.
module horner_poly_eval #(
  parameter int W        = 63,
  parameter int NCOEF    = 13,
  parameter int MUL_LAT  = 1,
  parameter int SCALE_EN = 1,
  parameter logic [NCOEF*(W+1)-1:0] COEF_INIT = {
    64'h8000000000000000, 64'h7FFFFFFFFFFF4800, 64'h400000000002B400,
    64'h155555555581FF00, 64'h0555555555070F00, 64'h011111110E066FD0,
    64'h002D82D8305B0FEA, 64'h000680681CF796E3, 64'h0000D00CF58F6F84,
    64'h0000171D939DE045, 64'h0000024FDCBF140A, 64'h00000036548CFC06,
    64'h00000004741183A3}
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [W-1:0]             z,
  input  logic [W-1:0]             ccs,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [W-1:0]             y,
  output logic                     busy,
  input  logic                     coef_we,
  input  logic [$clog2(NCOEF)-1:0] coef_addr,
  input  logic [W:0]               coef_wdata
);

  localparam int AW = $clog2(NCOEF);
  localparam int CW = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_MUL   = 3'd1;
  localparam logic [2:0] S_SUB   = 3'd2;
  localparam logic [2:0] S_SCALE = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [AW:0]   NCOEF_L  = (AW+1)'(NCOEF);
  localparam logic [AW-1:0] LAST_IDX = AW'(NCOEF - 1);
  localparam logic [AW-1:0] IDX_ZERO = AW'(0);
  localparam logic [AW-1:0] IDX_ONE  = AW'(1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(MUL_LAT - 1);

  // Q1.W coefficient into the Q0.W accumulator range
  function automatic logic [W-1:0] clamp_coef(input logic [W:0] c);
    if (c[W]) begin
      return {W{1'b1}};
    end else begin
      return c[W-1:0];
    end
  endfunction

  logic [2:0]      state_r, state_nx_s;
  logic [AW-1:0]   idx_r;
  logic [CW-1:0]   cnt_r;
  logic [W-1:0]    z_r, ccs_r, acc_r, y_r;
  logic [W:0]      coef_r [NCOEF];
  logic [W-1:0]    pipe_r [MUL_LAT];
  logic            in_ready_r, out_valid_r, busy_r;

  logic            coef_hit_s, last_s;
  logic [W:0]      c0_s, c_idx_s;
  logic [W-1:0]    p_s, sub_sat_s, mul_a_s, mul_b_s;
  logic [W-1:0]    prod_hi_s, prod_unused_s;
  logic [W+1:0]    diff_s;

  assign coef_hit_s = coef_we && (state_r == S_IDLE) && ({1'b0, coef_addr} < NCOEF_L);
  assign c0_s       = (coef_hit_s && (coef_addr == IDX_ZERO)) ? coef_wdata : coef_r[0];
  assign c_idx_s    = coef_r[idx_r];
  assign last_s     = (idx_r == LAST_IDX);
  assign p_s        = pipe_r[MUL_LAT-1];
  assign {prod_hi_s, prod_unused_s} = {{W{1'b0}}, mul_a_s} * {{W{1'b0}}, mul_b_s};

  // Saturating C[idx] - p
  always_comb begin
    diff_s = {1'b0, c_idx_s} - {2'b00, p_s};
    if (diff_s[W+1]) begin
      sub_sat_s = {W{1'b0}};
    end else if (diff_s[W]) begin
      sub_sat_s = {W{1'b1}};
    end else begin
      sub_sat_s = diff_s[W-1:0];
    end
  end

  // Multiplier operands; the scale product is launched from the final SUB so SCALE spans MUL_LAT cycles
  always_comb begin
    mul_a_s = z_r;
    mul_b_s = acc_r;
    if ((SCALE_EN != 0) && (state_r == S_SUB) && last_s) begin
      mul_a_s = ccs_r;
      mul_b_s = sub_sat_s;
    end else if (state_r == S_SCALE) begin
      mul_a_s = ccs_r;
      mul_b_s = acc_r;
    end else begin
      mul_a_s = z_r;
      mul_b_s = acc_r;
    end
  end

  // Next-state decode
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (in_valid) state_nx_s = S_MUL;
        else          state_nx_s = S_IDLE;
      end
      S_MUL: begin
        if (cnt_r == CNT_LAST) state_nx_s = S_SUB;
        else                   state_nx_s = S_MUL;
      end
      S_SUB: begin
        if (!last_s)            state_nx_s = S_MUL;
        else if (SCALE_EN != 0) state_nx_s = S_SCALE;
        else                    state_nx_s = S_DONE;
      end
      S_SCALE: begin
        if (cnt_r == CNT_LAST) state_nx_s = S_DONE;
        else                   state_nx_s = S_SCALE;
      end
      S_DONE: begin
        if (out_ready) state_nx_s = S_IDLE;
        else           state_nx_s = S_DONE;
      end
      default: state_nx_s = S_IDLE;
    endcase
  end

  // Control, datapath and registered status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= S_IDLE;
      idx_r       <= IDX_ZERO;
      cnt_r       <= CNT_ZERO;
      z_r         <= {W{1'b0}};
      ccs_r       <= {W{1'b0}};
      acc_r       <= {W{1'b0}};
      y_r         <= {W{1'b0}};
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_nx_s;
      in_ready_r  <= (state_nx_s == S_IDLE);
      out_valid_r <= (state_nx_s == S_DONE);
      busy_r      <= (state_nx_s != S_IDLE);
      case (state_r)
        S_IDLE: begin
          if (in_valid) begin
            z_r   <= z;
            ccs_r <= ccs;
            acc_r <= clamp_coef(c0_s);
            idx_r <= IDX_ONE;
            cnt_r <= CNT_ZERO;
          end
        end
        S_MUL: begin
          cnt_r <= (cnt_r == CNT_LAST) ? CNT_ZERO : cnt_r + CNT_ONE;
        end
        S_SUB: begin
          acc_r <= sub_sat_s;
          cnt_r <= CNT_ZERO;
          if (!last_s) idx_r <= idx_r + IDX_ONE;
          if (last_s && (SCALE_EN == 0)) y_r <= sub_sat_s;
        end
        S_SCALE: begin
          if (cnt_r == CNT_LAST) begin
            acc_r <= p_s;
            y_r   <= p_s;
            cnt_r <= CNT_ZERO;
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        S_DONE: begin
          cnt_r <= CNT_ZERO;
        end
        default: begin
          cnt_r <= CNT_ZERO;
        end
      endcase
    end
  end

  // Coefficient table: reload on reset, writable only while idle
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NCOEF; i++) coef_r[i] <= COEF_INIT[i*(W+1) +: (W+1)];
    end else if (coef_hit_s) begin
      for (int i = 0; i < NCOEF; i++) begin
        if (coef_addr == AW'(i)) coef_r[i] <= coef_wdata;
      end
    end
  end

  // Multiplier pipeline, keeps only the truncated upper half
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < MUL_LAT; i++) pipe_r[i] <= {W{1'b0}};
    end else begin
      pipe_r[0] <= prod_hi_s;
      for (int i = 1; i < MUL_LAT; i++) pipe_r[i] <= pipe_r[i-1];
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign busy      = busy_r;
  assign y         = y_r;

endmodule
